// File: rtl/alu_arbiter_pkg.sv
// Shared types and ALU_control opcodes for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
    } op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, one consumer and the arbiter.
interface alu_arbiter_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [3:0]  req0_ctrl;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [3:0]  req1_ctrl;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_cout;
    logic        rsp_overflow;

    logic        busy;
    logic [15:0] op_count;

    modport master (
        output req0_valid, req0_src1, req0_src2, req0_ctrl,
        output req1_valid, req1_src1, req1_src2, req1_ctrl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        input  rsp_zero, rsp_cout, rsp_overflow,
        input  busy, op_count
    );

    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_ctrl,
        input  req1_valid, req1_src1, req1_src2, req1_ctrl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        output rsp_zero, rsp_cout, rsp_overflow,
        output busy, op_count
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// 32-bit ALU with registered result/carry/overflow; zero derives from the
// registered result.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        cout_o,
    output logic        overflow_o
);

    logic        sub;
    logic [31:0] b_op;
    logic [32:0] sum;
    logic        ov;

    logic [31:0] result_d, result_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;

    // SUB and SLT share the adder as a + ~b + 1
    always_comb begin
        sub  = (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT);
        b_op = sub ? ~src2_i : src2_i;
        sum  = {1'b0, src1_i} + {1'b0, b_op} + {32'd0, sub};
        ov   = (src1_i[31] == b_op[31]) && (sum[31] != src1_i[31]);
    end

    always_comb begin
        result_d = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        unique case (ctrl_i)
            ALU_AND: result_d = src1_i & src2_i;
            ALU_OR:  result_d = src1_i | src2_i;
            ALU_NOR: result_d = ~(src1_i | src2_i);
            ALU_ADD, ALU_SUB: begin
                result_d = sum[31:0];
                cout_d   = sum[32];
                ovf_d    = ov;
            end
            ALU_SLT: result_d = {31'd0, sum[31] ^ ov};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = (result_q == '0);
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a registered ALU: accept in IDLE,
// compute in EXEC, hold the response in RESP until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic        any_req;
    logic        gnt_id;
    logic        accept;
    logic        rsp_hs;
    logic        rdy0, rdy1, rsp_vld, busy;

    logic [31:0] alu_res;
    logic        alu_zero, alu_cout, alu_ovf;

    // last_q holds the id granted most recently; reset value makes req0 win
    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        if (!bus.req1_valid)
            gnt_id = 1'b0;
        else if (!bus.req0_valid)
            gnt_id = 1'b1;
        else
            gnt_id = RR_EN ? ~last_q : 1'b0;
        accept = (state_q == IDLE) && any_req;
        rsp_hs = (state_q == RESP) && bus.rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy0    = (state_q == IDLE) && rst_n && any_req && !gnt_id;
        rdy1    = (state_q == IDLE) && rst_n && any_req && gnt_id;
        rsp_vld = (state_q == RESP);
        busy    = (state_q != IDLE);
    end

    always_comb begin
        op_d   = op_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (accept) begin
            last_d = gnt_id;
            if (gnt_id)
                op_d = '{id: 1'b1, ctrl: bus.req1_ctrl,
                         src1: bus.req1_src1, src2: bus.req1_src2};
            else
                op_d = '{id: 1'b0, ctrl: bus.req0_ctrl,
                         src1: bus.req0_src1, src2: bus.req0_src2};
        end
        if (rsp_hs) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            op_q   <= op_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    alu u_alu (
        .clk        (clk),
        .rst_n      (rst_n),
        .src1_i     (op_q.src1),
        .src2_i     (op_q.src2),
        .ctrl_i     (op_q.ctrl),
        .result_o   (alu_res),
        .zero_o     (alu_zero),
        .cout_o     (alu_cout),
        .overflow_o (alu_ovf)
    );

    assign bus.req0_ready   = rdy0;
    assign bus.req1_ready   = rdy1;
    assign bus.rsp_valid    = rsp_vld;
    assign bus.rsp_id       = op_q.id;
    assign bus.rsp_result   = rsp_vld ? alu_res : '0;
    assign bus.rsp_zero     = rsp_vld & alu_zero;
    assign bus.rsp_cout     = rsp_vld & alu_cout;
    assign bus.rsp_overflow = rsp_vld & alu_ovf;
    assign bus.busy         = busy;
    assign bus.op_count     = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table plus stall, reset and
// arbitration sequences on a round-robin and a fixed-priority instance.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if b0();
    alu_arbiter_if b1();

    alu_arbiter #(.RR_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    alu_arbiter #(.RR_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_cnt = '0;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        if (!id) begin
            b0.req0_valid = 1'b1; b0.req0_ctrl = c;
            b0.req0_src1 = a; b0.req0_src2 = b;
        end else begin
            b0.req1_valid = 1'b1; b0.req1_ctrl = c;
            b0.req1_src1 = a; b0.req1_src2 = b;
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        @(negedge clk);
        drive(v.id, v.ctrl, v.a, v.b);
        b0.rsp_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_ready", k),
            v.id ? b0.req1_ready : b0.req0_ready, 1);
        chk($sformatf("v%0d_idle_busy", k), b0.busy, 0);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        b0.req1_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_t1_valid", k), b0.rsp_valid, 0);
        chk($sformatf("v%0d_t1_busy", k), b0.busy, 1);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_t2_valid", k), b0.rsp_valid, 1);
        chk($sformatf("v%0d_result", k), b0.rsp_result, v.res);
        chk($sformatf("v%0d_zero", k), b0.rsp_zero, v.z);
        chk($sformatf("v%0d_cout", k), b0.rsp_cout, v.c);
        chk($sformatf("v%0d_ovf", k), b0.rsp_overflow, v.v);
        chk($sformatf("v%0d_id", k), b0.rsp_id, v.id);
        exp_cnt++;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_count", k), b0.op_count, exp_cnt);
        chk($sformatf("v%0d_t3_valid", k), b0.rsp_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int gcnt;
        int both;
        logic gid[8];
        int gcyc[8];
        logic last_g;

        vecs[0] = '{1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0,
                    32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, ALU_OR, 32'h12340000, 32'h00005678,
                    32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, ALU_NOR, 32'd0, 32'd0,
                    32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd1,
                    32'd1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, ALU_SLT, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, ALU_ADD, 32'hFFFFFFFF, 32'd1,
                    32'd0, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, ALU_SUB, 32'h80000000, 32'd1,
                    32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{1'b1, ALU_SUB, 32'd1, 32'd2,
                    32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        b0.req0_valid = 1'b1; b0.req0_ctrl = ALU_ADD;
        b0.req0_src1 = '0; b0.req0_src2 = '0;
        b0.req1_valid = 1'b0; b0.req1_ctrl = ALU_ADD;
        b0.req1_src1 = '0; b0.req1_src2 = '0;
        b0.rsp_ready = 1'b1;
        b1.req0_valid = 1'b0; b1.req0_ctrl = ALU_ADD;
        b1.req0_src1 = '0; b1.req0_src2 = '0;
        b1.req1_valid = 1'b0; b1.req1_ctrl = ALU_ADD;
        b1.req1_src1 = '0; b1.req1_src2 = '0;
        b1.rsp_ready = 1'b1;

        // reset state, with a request pending that must not see ready
        #12;
        chk("rst_ready0", b0.req0_ready, 0);
        chk("rst_valid", b0.rsp_valid, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_count", b0.op_count, 0);
        chk("rst_id", b0.rsp_id, 0);
        b0.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

        // response back-pressure with a competing request waiting
        @(negedge clk);
        drive(1'b0, ALU_ADD, 32'h7FFFFFFF, 32'd1);
        b0.rsp_ready = 1'b0;
        #1;
        chk("st_accept", b0.req0_ready, 1);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        drive(1'b1, ALU_ADD, 32'd1, 32'd1);
        #1;
        chk("st_exec_ready1", b0.req1_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("st%0d_valid", i), b0.rsp_valid, 1);
            chk($sformatf("st%0d_result", i), b0.rsp_result, 32'h80000000);
            chk($sformatf("st%0d_ovf", i), b0.rsp_overflow, 1);
            chk($sformatf("st%0d_cout", i), b0.rsp_cout, 0);
            chk($sformatf("st%0d_zero", i), b0.rsp_zero, 0);
            chk($sformatf("st%0d_id", i), b0.rsp_id, 0);
            chk($sformatf("st%0d_ready", i),
                {31'd0, b0.req0_ready | b0.req1_ready}, 0);
            chk($sformatf("st%0d_count", i), b0.op_count, exp_cnt);
        end
        b0.rsp_ready = 1'b1;
        exp_cnt++;
        @(negedge clk);
        #1;
        chk("st_done_valid", b0.rsp_valid, 0);
        chk("st_done_count", b0.op_count, exp_cnt);
        chk("st_next_ready1", b0.req1_ready, 1);
        @(negedge clk);
        b0.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("st_next_valid", b0.rsp_valid, 1);
        chk("st_next_result", b0.rsp_result, 2);
        chk("st_next_id", b0.rsp_id, 1);
        exp_cnt++;
        @(negedge clk);

        // asynchronous reset while an operation is in EXEC
        @(negedge clk);
        drive(1'b1, ALU_ADD, 32'd1, 32'd2);
        #1;
        chk("rx_accept", b0.req1_ready, 1);
        @(negedge clk);
        #1;
        chk("rx_exec_busy", b0.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rx_valid", b0.rsp_valid, 0);
        chk("rx_ready1", b0.req1_ready, 0);
        chk("rx_busy", b0.busy, 0);
        chk("rx_count", b0.op_count, 0);
        chk("rx_id", b0.rsp_id, 0);
        chk("rx_result", b0.rsp_result, 0);
        chk("rx_zero", b0.rsp_zero, 0);
        b0.req1_valid = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (b0.rsp_valid) seen++;
        end
        chk("rx_no_rsp", seen, 0);
        run_vec(20, '{1'b0, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0});

        // round-robin with both requesters always valid
        do_reset();
        @(negedge clk);
        drive(1'b0, ALU_ADD, 32'd10, 32'd1);
        drive(1'b1, ALU_ADD, 32'd20, 32'd2);
        b0.rsp_ready = 1'b1;
        gcnt = 0;
        both = 0;
        last_g = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (b0.req0_ready && b0.req1_ready) both++;
            if (b0.rsp_valid) begin
                chk($sformatf("rr_rsp%0d", i), b0.rsp_result,
                    last_g ? 32'd22 : 32'd11);
                chk($sformatf("rr_id%0d", i), b0.rsp_id, last_g);
            end
            if (b0.req0_ready || b0.req1_ready) begin
                if (gcnt < 8) begin
                    gid[gcnt] = b0.req1_ready;
                    gcyc[gcnt] = i;
                end
                gcnt++;
                last_g = b0.req1_ready;
            end
        end
        chk("rr_both", both, 0);
        chk("rr_grants", gcnt, 4);
        for (int k = 0; k < 4 && k < gcnt; k++) begin
            chk($sformatf("rr_gid%0d", k), gid[k], k % 2);
            chk($sformatf("rr_gcyc%0d", k), gcyc[k], 3 * k);
        end
        @(negedge clk);
        b0.req0_valid = 1'b0;
        b0.req1_valid = 1'b0;
        #1;
        chk("rr_count", b0.op_count, 4);

        // fixed priority instance with both requesters always valid
        @(negedge clk);
        b1.req0_valid = 1'b1; b1.req0_src1 = 32'd1; b1.req0_src2 = 32'd1;
        b1.req1_valid = 1'b1; b1.req1_src1 = 32'd9; b1.req1_src2 = 32'd9;
        gcnt = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (b1.req1_ready) seen++;
            if (b1.req0_ready) begin
                if (gcnt < 8) gcyc[gcnt] = i;
                gcnt++;
            end
            if (b1.rsp_valid) begin
                chk($sformatf("fp_rsp%0d", i), b1.rsp_result, 2);
                chk($sformatf("fp_id%0d", i), b1.rsp_id, 0);
            end
        end
        chk("fp_ready1", seen, 0);
        chk("fp_grants", gcnt, 4);
        for (int k = 0; k < 4 && k < gcnt; k++)
            chk($sformatf("fp_gcyc%0d", k), gcyc[k], 3 * k);
        @(negedge clk);
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        #1;
        chk("fp_count", b1.op_count, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
